// File: rtl/simple_dma_controller.sv
`default_nettype none
// ============================================================================
// Module      : simple_dma_controller
// Description : DMA engine sitting behind a simple DMA peripheral. Latches the
//               device's start address, word count and direction, then moves
//               16-bit words between data memory and the device through a
//               single-outstanding memory master port.
//               Read  (dir=1): REQ -> RWAIT -> XFER per word (memory->device)
//               Write (dir=0): XFER -> REQ per word           (device->memory)
// Ports       : clk, reset (sync, active-low)
//               dma_rqst/dma_rd_wr/dma_start_address/dma_num_words : request
//               dev_ack/dev_out   : device handshake and write data
//               dma_ack/dev_in    : per-word strobe and read data to device
//               dma_end_flag      : one-cycle pulse at normal completion
//               dma_busy          : high whenever the FSM is not idle
//               mem_req/mem_we/mem_addr/mem_wdata/mem_gnt/mem_rdata : memory
// Revision    : 1.0 - initial release
// ============================================================================
module simple_dma_controller #(
  parameter int ADDR_INC = 2,
  parameter bit ABORT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dma_rqst,
  input  logic        dma_rd_wr,
  input  logic [15:0] dma_start_address,
  input  logic [15:0] dma_num_words,
  input  logic        dev_ack,
  input  logic [15:0] dev_out,
  output logic        dma_ack,
  output logic [15:0] dev_in,
  output logic        dma_end_flag,
  output logic        dma_busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic [15:0] mem_rdata
);

  localparam logic [15:0] c_ADDR_INC = ADDR_INC[15:0];

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_REQ   = 3'd1;
  localparam logic [2:0] c_RWAIT = 3'd2;
  localparam logic [2:0] c_XFER  = 3'd3;
  localparam logic [2:0] c_DONE  = 3'd4;

  logic [2:0]  r_state;
  logic [15:0] r_addr;
  logic [15:0] r_cnt;
  logic [15:0] r_buf;
  logic        r_dir;
  logic        r_end;
  logic        w_abort;
  logic        w_last;

  assign w_abort = ABORT_EN & ~dma_rqst;
  // The word being completed is the final one of the transfer.
  assign w_last  = (r_cnt == 16'd1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= c_IDLE;
      r_addr  <= 16'd0;
      r_cnt   <= 16'd0;
      r_buf   <= 16'd0;
      r_dir   <= 1'b0;
      r_end   <= 1'b0;
    end else begin
      r_end <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (dma_rqst) begin
            r_addr <= dma_start_address;
            r_cnt  <= dma_num_words;
            r_dir  <= dma_rd_wr;
            if (dma_num_words == 16'd0) begin
              r_state <= c_DONE;
              r_end   <= 1'b1;
            end else if (dma_rd_wr) begin
              r_state <= c_REQ;
            end else begin
              r_state <= c_XFER;
            end
          end
        end

        // Abort is only honoured after the grant: an issued access is never
        // withdrawn.
        c_REQ: begin
          if (mem_gnt) begin
            if (r_dir) begin
              r_state <= c_RWAIT;
            end else begin
              r_addr <= r_addr + c_ADDR_INC;
              r_cnt  <= r_cnt - 16'd1;
              if (w_last) begin
                r_state <= c_DONE;
                r_end   <= 1'b1;
              end else if (w_abort) begin
                r_state <= c_IDLE;
              end else begin
                r_state <= c_XFER;
              end
            end
          end
        end

        // The granted read always lands in the buffer, even when aborting.
        c_RWAIT: begin
          r_buf   <= mem_rdata;
          r_state <= w_abort ? c_IDLE : c_XFER;
        end

        // A device ack wins over a simultaneous abort.
        c_XFER: begin
          if (dev_ack) begin
            if (r_dir) begin
              r_addr <= r_addr + c_ADDR_INC;
              r_cnt  <= r_cnt - 16'd1;
              if (w_last) begin
                r_state <= c_DONE;
                r_end   <= 1'b1;
              end else begin
                r_state <= c_REQ;
              end
            end else begin
              r_buf   <= dev_out;
              r_state <= c_REQ;
            end
          end else if (w_abort) begin
            r_state <= c_IDLE;
          end
        end

        // Hold here until the device withdraws its request so a still-high
        // level does not start a second transfer.
        c_DONE: begin
          if (!dma_rqst) begin
            r_state <= c_IDLE;
          end
        end

        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign mem_req      = (r_state == c_REQ);
  assign mem_we       = mem_req & ~r_dir;
  assign mem_addr     = mem_req ? r_addr : 16'd0;
  assign mem_wdata    = mem_req ? r_buf  : 16'd0;
  assign dma_ack      = (r_state == c_XFER) & dev_ack;
  assign dev_in       = (dma_ack & r_dir) ? r_buf : 16'd0;
  assign dma_busy     = (r_state != c_IDLE);
  assign dma_end_flag = r_end;

endmodule
`default_nettype wire

// File: tb/tb_simple_dma_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_simple_dma_controller
// Description : Self-checking bench for simple_dma_controller. A table of
//               directed transfers plus randomized transfers are checked
//               against a transfer-level model (expected address list, data
//               list and end-flag count); hand-written sequences cover abort
//               and mid-operation reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simple_dma_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        dma_rqst;
  logic        dma_rd_wr;
  logic [15:0] dma_start_address;
  logic [15:0] dma_num_words;
  logic        dev_ack;
  logic [15:0] dev_out;
  logic        dma_ack;
  logic [15:0] dev_in;
  logic        dma_end_flag;
  logic        dma_busy;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_gnt;
  logic [15:0] mem_rdata;

  always #5 clk = ~clk;

  simple_dma_controller #(.ADDR_INC(2), .ABORT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .dma_rqst(dma_rqst), .dma_rd_wr(dma_rd_wr),
    .dma_start_address(dma_start_address), .dma_num_words(dma_num_words),
    .dev_ack(dev_ack), .dev_out(dev_out), .dma_ack(dma_ack), .dev_in(dev_in),
    .dma_end_flag(dma_end_flag), .dma_busy(dma_busy), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rdata(mem_rdata)
  );

  typedef struct {
    bit          dir;
    logic [15:0] start;
    int          n;
    int          gmode;     // 0: always grant, 1: withhold 4 cycles, 2: random
    int          amode;     // 0: dev_ack always 1, 1: random
    int          exp_acc;
    logic [15:0] exp_last;
    int          exp_space; // cycles between words, 0 = not checked
  } vec_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int req_cyc;

  logic [15:0] mem      [0:65535];
  logic [15:0] dev_vals [0:63];
  logic [15:0] exp_rd   [0:63];

  int          gmode, amode, stall_cnt, dev_idx;
  bit          rd_pend;
  logic [15:0] rd_addr;
  bit          held_v;
  logic [15:0] held_addr, held_wdata;
  logic        held_we;

  logic [15:0] acc_addr[$];
  logic [15:0] acc_data[$];
  logic        acc_we[$];
  int          acc_cyc[$];
  logic [15:0] ack_data[$];
  int          ack_cyc[$];
  int          end_cnt, end_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive the memory/device responders at the falling edge, then
  // observe the DUT and log accesses, acks and end flags.
  task automatic tick();
    @(negedge clk);
    mem_rdata = rd_pend ? mem[rd_addr] : 16'($urandom);
    rd_pend = 1'b0;
    if (gmode == 0) begin
      mem_gnt = 1'b1;
    end else if (gmode == 1) begin
      if (mem_req && stall_cnt < 4) begin
        mem_gnt = 1'b0;
        stall_cnt++;
      end else begin
        mem_gnt = mem_req;
        stall_cnt = 0;
      end
    end else begin
      mem_gnt = ($urandom_range(0, 2) != 0);
    end
    dev_ack = (amode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    dev_out = (dev_idx < 64) ? dev_vals[dev_idx] : 16'hBEEF;
    #1;
    if (mem_req) begin
      if (held_v) begin
        chk("hold_addr", mem_addr, held_addr);
        chk("hold_we", mem_we, held_we);
        chk("hold_wdata", mem_wdata, held_wdata);
      end
      if (mem_gnt) begin
        acc_addr.push_back(mem_addr);
        acc_data.push_back(mem_wdata);
        acc_we.push_back(mem_we);
        acc_cyc.push_back(cyc);
        if (mem_we) mem[mem_addr] = mem_wdata;
        else begin
          rd_pend = 1'b1;
          rd_addr = mem_addr;
        end
        held_v = 1'b0;
      end else begin
        held_v     = 1'b1;
        held_addr  = mem_addr;
        held_we    = mem_we;
        held_wdata = mem_wdata;
      end
    end else begin
      held_v = 1'b0;
    end
    if (dma_ack) begin
      ack_data.push_back(dev_in);
      ack_cyc.push_back(cyc);
      dev_idx++;
    end else begin
      chk("dev_in_idle", dev_in, 0);
    end
    if (dma_end_flag) begin
      end_cnt++;
      end_cyc = cyc;
    end
    cyc++;
  endtask

  task automatic clear_logs();
    acc_addr.delete(); acc_data.delete(); acc_we.delete(); acc_cyc.delete();
    ack_data.delete(); ack_cyc.delete();
    end_cnt = 0; end_cyc = -1; held_v = 1'b0; rd_pend = 1'b0;
    stall_cnt = 0; dev_idx = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_dma_ack"}, dma_ack, 0);
    chk({tag, "_dev_in"}, dev_in, 0);
    chk({tag, "_end_flag"}, dma_end_flag, 0);
    chk({tag, "_busy"}, dma_busy, 0);
  endtask

  // Transfer-level model: word i lives at start + 2*i (16-bit wrap); reads
  // deliver the memory snapshot, writes store the i-th device word.
  task automatic verify(input bit dir, input logic [15:0] start, input int n);
    logic [15:0] a;
    chk("acc_count", 32'(acc_addr.size()), 32'(n));
    chk("ack_count", 32'(ack_data.size()), 32'(n));
    for (int i = 0; i < n && i < acc_addr.size(); i++) begin
      a = start + 16'(2 * i);
      chk("acc_addr", acc_addr[i], a);
      chk("acc_we", acc_we[i], !dir);
      if (!dir) chk("wr_data", acc_data[i], dev_vals[i]);
    end
    if (dir) begin
      for (int i = 0; i < n && i < ack_data.size(); i++)
        chk("rd_data", ack_data[i], exp_rd[i]);
    end
    chk("end_count", 32'(end_cnt), 1);
  endtask

  task automatic run_xfer(input bit dir, input logic [15:0] start, input int n);
    int guard;
    clear_logs();
    for (int i = 0; i < n; i++) exp_rd[i] = mem[start + 16'(2 * i)];
    dma_rqst = 1'b1;
    dma_rd_wr = dir;
    dma_start_address = start;
    dma_num_words = 16'(n);
    req_cyc = cyc;
    tick();
    // Later changes on the request inputs must be ignored.
    dma_rd_wr = ~dir;
    dma_start_address = 16'($urandom);
    dma_num_words = 16'($urandom);
    guard = 0;
    while (end_cnt == 0 && guard < 2000) begin
      tick();
      guard++;
    end
    chk("end_seen", end_cnt != 0, 1);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("busy_in_done", dma_busy, 1);
    end
    dma_rqst = 1'b0;
    tick();
    chk("idle_after_drop", dma_busy, 0);
    verify(dir, start, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [7];
    vecs[0] = '{1'b1, 16'h0200, 3, 0, 0, 3, 16'h0204, 3};
    vecs[1] = '{1'b0, 16'h0300, 2, 0, 0, 2, 16'h0302, 2};
    vecs[2] = '{1'b1, 16'h0400, 3, 1, 0, 3, 16'h0404, 0};
    vecs[3] = '{1'b0, 16'h0500, 3, 1, 0, 3, 16'h0504, 0};
    vecs[4] = '{1'b1, 16'h0000, 0, 0, 0, 0, 16'h0000, 0};
    vecs[5] = '{1'b1, 16'hFFFE, 2, 0, 0, 2, 16'h0000, 3};
    vecs[6] = '{1'b0, 16'hFFFC, 3, 0, 0, 3, 16'h0000, 2};

    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[16'h0200] = 16'h1111;
    mem[16'h0202] = 16'h2222;
    mem[16'h0204] = 16'h3333;
    for (int i = 0; i < 64; i++) dev_vals[i] = 16'h00A5 + 16'(i);

    reset = 1'b0; dma_rqst = 1'b0; dma_rd_wr = 1'b0;
    dma_start_address = 16'd0; dma_num_words = 16'd0;
    dev_ack = 1'b0; dev_out = 16'd0; mem_gnt = 1'b0; mem_rdata = 16'd0;
    gmode = 0; amode = 0;
    clear_logs();
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b1;
    tick();

    // Directed table
    for (int v = 0; v < 7; v++) begin
      gmode = vecs[v].gmode;
      amode = vecs[v].amode;
      for (int i = 0; i < 64; i++) dev_vals[i] = 16'h00A5 + 16'(i);
      run_xfer(vecs[v].dir, vecs[v].start, vecs[v].n);
      chk("tbl_acc_count", 32'(acc_addr.size()), 32'(vecs[v].exp_acc));
      if (acc_addr.size() > 0) chk("tbl_last_addr", acc_addr[$], vecs[v].exp_last);
      if (vecs[v].n == 0) chk("zero_end_latency", 32'(end_cyc - req_cyc), 0);
      if (vecs[v].exp_space != 0) begin
        if (vecs[v].dir) begin
          for (int i = 1; i < ack_cyc.size(); i++)
            chk("read_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'(vecs[v].exp_space));
        end else begin
          for (int i = 1; i < acc_cyc.size(); i++)
            chk("write_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(vecs[v].exp_space));
        end
      end
    end

    // Randomized transfers against the model
    gmode = 2;
    amode = 1;
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 64; i++) dev_vals[i] = 16'($urandom);
      run_xfer(1'($urandom_range(0, 1)), 16'($urandom) & 16'hFFFE, $urandom_range(0, 8));
    end

    // Abort while a read access is stalled: the read still completes, no ack
    // reaches the device and no end flag is raised.
    clear_logs();
    gmode = 1;
    amode = 0;
    dma_rqst = 1'b1; dma_rd_wr = 1'b1;
    dma_start_address = 16'h0600; dma_num_words = 16'd3;
    tick();
    tick();
    tick();
    dma_rqst = 1'b0;
    repeat (10) tick();
    chk("abort_acc", 32'(acc_addr.size()), 1);
    if (acc_addr.size() > 0) chk("abort_addr", acc_addr[0], 16'h0600);
    chk("abort_acks", 32'(ack_data.size()), 0);
    chk("abort_end", 32'(end_cnt), 0);
    chk("abort_idle", dma_busy, 0);

    // Reset in the middle of a write
    clear_logs();
    gmode = 0;
    for (int i = 0; i < 64; i++) dev_vals[i] = 16'h5A00 + 16'(i);
    dma_rqst = 1'b1; dma_rd_wr = 1'b0;
    dma_start_address = 16'h0700; dma_num_words = 16'd4;
    tick();
    tick();
    tick();
    chk("pre_reset_busy", dma_busy, 1);
    reset = 1'b0;
    tick();
    check_all_zero("midreset");
    chk("midreset_acc", 32'(acc_addr.size()), 1);
    reset = 1'b1;
    dma_rqst = 1'b0;
    tick();
    chk("post_reset_idle", dma_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
